// File: rtl/rotate_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : rotate_pkg
// Brief  : Shared types and defaults for the rotate sequencer: FSM state
//          encoding and the default page-index width.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
package rotate_pkg;

  // Default width of the datapath page address
  localparam int DEFAULT_IDX_W = 10;

  // Sequencer states; explicit 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_WRITE  = 3'd3,
    ST_DONE   = 3'd4
  } rotate_state_e;

endpackage : rotate_pkg
`default_nettype wire

// File: rtl/rotate_page_counter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : rotate_page_counter
// Brief  : Loadable page-index counter. Loads the first page index and page
//          count on run start, steps the index modulo 2^IDX_W, counts pages
//          written and flags when the page being written is the last one.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
module rotate_page_counter
  import rotate_pkg::*;
#(
  parameter int IDX_W = DEFAULT_IDX_W
) (
  input  logic             clk,
  input  logic             rst,            // asynchronous, active-low
  input  logic             i_load,         // accepted start: latch run parameters
  input  logic [IDX_W-1:0] i_first_index,
  input  logic [IDX_W:0]   i_page_count,
  input  logic             i_page_written, // a page write completes this cycle
  input  logic             i_advance,      // step to the next page index
  output logic [IDX_W-1:0] o_file_index,
  output logic [IDX_W:0]   o_pages_done,
  output logic             o_last_page     // page currently in flight is the last
);

  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [IDX_W:0]   PD_ONE  = (IDX_W + 1)'(1);

  logic [IDX_W-1:0] r_index;
  logic [IDX_W:0]   r_pages_done;
  logic [IDX_W:0]   r_page_count;

  // Run parameters latch on load; index wraps naturally at 2^IDX_W
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_index      <= '0;
      r_pages_done <= '0;
      r_page_count <= '0;
    end else if (i_load) begin
      r_index      <= i_first_index;
      r_pages_done <= '0;
      r_page_count <= i_page_count;
    end else begin
      if (i_page_written) begin
        r_pages_done <= r_pages_done + PD_ONE;
      end
      if (i_advance) begin
        r_index <= r_index + IDX_ONE;
      end
    end
  end

  // pages_done never exceeds page_count-1 while a page is in flight, so the
  // +1 cannot overflow the IDX_W+1 bit field.
  assign o_last_page  = ((r_pages_done + PD_ONE) == r_page_count);
  assign o_file_index = r_index;
  assign o_pages_done = r_pages_done;

endmodule : rotate_page_counter
`default_nettype wire

// File: rtl/rotate_controller.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : rotate_controller
// Brief  : Sequencer for the rotate datapath. For each page of a run it
//          strobes read_file, waits SETTLE_CYCLES for the combinational
//          rotate, then strobes write_file. Reports busy/done/progress.
//          Optional feature macro: ROTATE_CTRL_STALL_EN adds a 'stall' input
//          that freezes the sequencer outside IDLE/DONE.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
module rotate_controller
  import rotate_pkg::*;
#(
  parameter int IDX_W         = DEFAULT_IDX_W,
  parameter int SETTLE_CYCLES = 1              // must be >= 1
) (
  input  logic             clk,
  input  logic             rst,          // asynchronous, active-low
  input  logic             start,
  input  logic [IDX_W-1:0] first_index,
  input  logic [IDX_W:0]   page_count,
`ifdef ROTATE_CTRL_STALL_EN
  input  logic             stall,
`endif
  output logic             read_file,
  output logic             write_file,
  output logic [IDX_W-1:0] file_index,
  output logic             busy,
  output logic             done,
  output logic [IDX_W:0]   pages_done
);

  // A zero settle count would collapse SETTLE; refuse to elaborate it.
  generate
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
      illegal_settle_cycles_parameter u_illegal ();
    end
  endgenerate

  localparam int                SET_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0]  SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [SET_W-1:0]  SET_ONE     = SET_W'(1);

  rotate_state_e    r_state;
  logic [SET_W-1:0] r_settle_cnt;
  logic             r_read_file;
  logic             r_write_file;
  logic             r_busy;
  logic             r_done;

  logic             w_stall;
  logic             w_load;
  logic             w_page_written;
  logic             w_advance;
  logic             w_last_page;

`ifdef ROTATE_CTRL_STALL_EN
  // Stall only matters while a page is in flight
  assign w_stall = stall && (r_state != ST_IDLE) && (r_state != ST_DONE);
`else
  assign w_stall = 1'b0;
`endif

  assign w_load         = (r_state == ST_IDLE) && start;
  assign w_page_written = (r_state == ST_WRITE) && !w_stall;
  assign w_advance      = w_page_written && !w_last_page;

  rotate_page_counter #(
    .IDX_W (IDX_W)
  ) u_page_counter (
    .clk            (clk),
    .rst            (rst),
    .i_load         (w_load),
    .i_first_index  (first_index),
    .i_page_count   (page_count),
    .i_page_written (w_page_written),
    .i_advance      (w_advance),
    .o_file_index   (file_index),
    .o_pages_done   (pages_done),
    .o_last_page    (w_last_page)
  );

  // Sequencer: state, settle counter and registered strobes/status advance together
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_settle_cnt <= '0;
      r_read_file  <= 1'b0;
      r_write_file <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            if (page_count == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state     <= ST_READ;
              r_read_file <= 1'b1;
            end
          end
        end

        ST_READ: begin
          if (!w_stall) begin
            r_read_file  <= 1'b0;
            r_settle_cnt <= SETTLE_LOAD;
            r_state      <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (!w_stall) begin
            if (r_settle_cnt == '0) begin
              r_state      <= ST_WRITE;
              r_write_file <= 1'b1;
            end else begin
              r_settle_cnt <= r_settle_cnt - SET_ONE;
            end
          end
        end

        ST_WRITE: begin
          if (!w_stall) begin
            r_write_file <= 1'b0;
            if (w_last_page) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state     <= ST_READ;
              r_read_file <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_state      <= ST_IDLE;
          r_read_file  <= 1'b0;
          r_write_file <= 1'b0;
          r_busy       <= 1'b0;
          r_done       <= 1'b0;
        end
      endcase
    end
  end

  // A held strobe is masked while stalled and fires on the first free cycle
  assign read_file  = r_read_file  && !w_stall;
  assign write_file = r_write_file && !w_stall;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule : rotate_controller
`default_nettype wire
